// File: rtl/avalon_mm_arbiter.sv
// N-host to 1-agent Avalon-MM arbiter with a registered grant and one transaction per grant.
// Define ARB_ROUND_ROBIN_EN for round-robin selection; otherwise the lowest requesting index wins.
module avalon_mm_arbiter #(
    parameter  int N_HOSTS = 2,
    parameter  int ADDR_W  = 32,
    parameter  int DATA_W  = 32,
    localparam int BE_W    = DATA_W / 8,
    localparam int IDX_W   = (N_HOSTS > 1) ? $clog2(N_HOSTS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_HOSTS*ADDR_W-1:0]  h_address,
    input  logic [N_HOSTS-1:0]         h_read,
    input  logic [N_HOSTS-1:0]         h_write,
    input  logic [N_HOSTS*DATA_W-1:0]  h_writedata,
    input  logic [N_HOSTS*BE_W-1:0]    h_byteenable,
    output logic [DATA_W-1:0]          h_readdata,
    output logic [N_HOSTS-1:0]         h_waitrequest,
    output logic [ADDR_W-1:0]          a_address,
    output logic                       a_read,
    output logic                       a_write,
    output logic [DATA_W-1:0]          a_writedata,
    output logic [BE_W-1:0]            a_byteenable,
    input  logic [DATA_W-1:0]          a_readdata,
    input  logic                       a_waitrequest,
    output logic [IDX_W-1:0]           grant_idx,
    output logic                       busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_grant_idx;
    logic                 r_busy;
    logic [N_HOSTS-1:0]   w_req;
    logic                 w_granted;
`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]     r_rr_ptr;

    // First requester strictly after the pointer, wrapping from N_HOSTS-1 back to 0.
    function automatic logic [IDX_W-1:0] pick_winner(input logic [N_HOSTS-1:0] req,
                                                     input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] win;
        logic             found;
        int               idx;
        win   = {IDX_W{1'b0}};
        found = 1'b0;
        for (int k = 1; k <= N_HOSTS; k++) begin
            idx = (int'(ptr) + k) % N_HOSTS;
            if (!found && req[idx]) begin
                win   = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction
`else
    function automatic logic [IDX_W-1:0] pick_winner(input logic [N_HOSTS-1:0] req);
        logic [IDX_W-1:0] win;
        win = {IDX_W{1'b0}};
        for (int k = N_HOSTS - 1; k >= 0; k--) begin
            if (req[k]) begin
                win = IDX_W'(k);
            end
        end
        return win;
    endfunction
`endif

    assign w_req      = h_read | h_write;
    assign w_granted  = (r_state == ST_GRANT);
    assign grant_idx  = r_grant_idx;
    assign busy       = r_busy;
    assign h_readdata = a_readdata;

    // Agent-side mux; strobes and payload are forced to zero outside GRANT so reset drops them at once.
    always_comb begin
        a_address     = {ADDR_W{1'b0}};
        a_read        = 1'b0;
        a_write       = 1'b0;
        a_writedata   = {DATA_W{1'b0}};
        a_byteenable  = {BE_W{1'b0}};
        h_waitrequest = {N_HOSTS{1'b1}};
        if (w_granted) begin
            a_address     = h_address[r_grant_idx*ADDR_W +: ADDR_W];
            a_write       = h_write[r_grant_idx];
            a_read        = h_read[r_grant_idx] & ~h_write[r_grant_idx];
            a_writedata   = h_writedata[r_grant_idx*DATA_W +: DATA_W];
            a_byteenable  = h_byteenable[r_grant_idx*BE_W +: BE_W];
            h_waitrequest[r_grant_idx] = a_waitrequest;
        end else begin
            h_waitrequest = {N_HOSTS{1'b1}};
        end
    end

    // Arbitration FSM: sample requests only in IDLE, hold the grant until completion or request drop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_grant_idx <= {IDX_W{1'b0}};
            r_busy      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_rr_ptr    <= IDX_W'(N_HOSTS - 1);
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                        r_grant_idx <= pick_winner(w_req, r_rr_ptr);
`else
                        r_grant_idx <= pick_winner(w_req);
`endif
                        r_state     <= ST_GRANT;
                        r_busy      <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (!w_req[r_grant_idx]) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (!a_waitrequest) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                        r_rr_ptr <= r_grant_idx;
`endif
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
